// File: rtl/mem_gen_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_gen_ctrl_if
//   Request/response bundle between a bus-side requester (master) and the
//   mem_gen_ctrl scratch store (slave).
//
//   Handshake: a request transfers on a rising clock edge where both
//   req_valid and req_ready are 1. req_ready never depends on req_valid.
//   While req_valid=1 and req_ready=0 the master holds the request
//   (wr_en/addr/wr_data/wr_be) stable until it is accepted. Reads answer
//   with a one-cycle rd_valid pulse carrying rd_data, in request order;
//   there is no back-pressure on the response side.
//
//   Signals
//     chip_en    m->s  block enable, 0 blocks new requests
//     req_valid  m->s  request present
//     req_ready  s->m  request can be accepted this cycle
//     wr_en      m->s  1 = write, 0 = read
//     addr       m->s  word address
//     wr_data    m->s  write data
//     wr_be      m->s  byte enables, bit i covers wr_data[8i+7:8i]
//     rd_data    s->m  read data, valid while rd_valid=1, held otherwise
//     rd_valid   s->m  one pulse per accepted read
//     init_done  s->m  clear sweep finished
//     dbg_state  s->m  controller FSM state (0 = S_INIT, 1 = S_RUN)
// ---------------------------------------------------------------------------
interface mem_gen_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
);
  logic                  chip_en;
  logic                  req_valid;
  logic                  req_ready;
  logic                  wr_en;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wr_data;
  logic [DATA_W/8-1:0]   wr_be;
  logic [DATA_W-1:0]     rd_data;
  logic                  rd_valid;
  logic                  init_done;
  logic                  dbg_state;

  modport master (
    output chip_en, req_valid, wr_en, addr, wr_data, wr_be,
    input  req_ready, rd_data, rd_valid, init_done, dbg_state
  );

  modport slave (
    input  chip_en, req_valid, wr_en, addr, wr_data, wr_be,
    output req_ready, rd_data, rd_valid, init_done, dbg_state
  );
endinterface

// File: rtl/mem_gen_ctrl.sv
// ---------------------------------------------------------------------------
// mem_gen_ctrl
//   Parametrised single-port scratch memory with a valid/ready request port,
//   byte-enable writes, optional read output register and a post-reset
//   clear sweep.
//
//   Parameters
//     DATA_W      data width, multiple of 8
//     ADDR_W      address width, DEPTH = 2**ADDR_W words
//     OUT_REG     0: read latency 1, 1: read latency 2
//     INIT_CLEAR  1: zero every word after reset before taking requests
//
//   Ports
//     clock   rising-edge clock
//     rst_n   asynchronous active-low reset
//     bus     mem_gen_ctrl_if slave modport (request/response bundle)
// ---------------------------------------------------------------------------
module mem_gen_ctrl #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 10,
  parameter bit OUT_REG    = 1'b1,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic           clock,
  input  logic           rst_n,
  mem_gen_ctrl_if.slave  bus
);

  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  generate
    if (DATA_W % 8 != 0) begin : g_width_check
      $error("mem_gen_ctrl: DATA_W must be a multiple of 8");
    end
  endgenerate

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   init_ptr_q, init_ptr_d;

  // Read pipeline: stage 1 is only observed when OUT_REG=1.
  logic                rd_v1_q, rd_v1_d;
  logic [DATA_W-1:0]   rd_d1_q, rd_d1_d;
  logic                rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;

  logic                accept;
  logic                rd_accept;

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [BE_W-1:0]     mem_wbe;
  logic [DATA_W-1:0]   mem_rdata;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  assign bus.req_ready = (state_q == S_RUN) && bus.chip_en;
  assign accept        = bus.req_valid && bus.req_ready;
  assign rd_accept     = accept && !bus.wr_en;
  assign mem_rdata     = mem_q[bus.addr];

  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.init_done = (state_q == S_RUN);
  assign bus.dbg_state = state_q;

  // FSM next state and memory write port selection.
  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    mem_we     = 1'b0;
    mem_waddr  = bus.addr;
    mem_wdata  = bus.wr_data;
    mem_wbe    = bus.wr_be;
    case (state_q)
      S_INIT: begin
        if (INIT_CLEAR) begin
          mem_we    = 1'b1;
          mem_waddr = init_ptr_q;
          mem_wdata = '0;
          mem_wbe   = '1;
          // Pointer parks on the last word instead of wrapping.
          if (init_ptr_q == LAST_ADDR) begin
            state_d = S_RUN;
          end else begin
            init_ptr_d = init_ptr_q + 1'b1;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        mem_we = accept && bus.wr_en;
      end
      default: state_d = S_INIT;
    endcase
  end

  // Read response path. rd_data only moves when a response is produced,
  // so it holds the last returned word between pulses.
  always_comb begin
    rd_v1_d = rd_accept;
    rd_d1_d = rd_accept ? mem_rdata : rd_d1_q;
    if (OUT_REG) begin
      rd_valid_d = rd_v1_q;
      rd_data_d  = rd_v1_q ? rd_d1_q : rd_data_q;
    end else begin
      rd_valid_d = rd_accept;
      rd_data_d  = rd_accept ? mem_rdata : rd_data_q;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_INIT;
      init_ptr_q <= '0;
      rd_v1_q    <= 1'b0;
      rd_d1_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      rd_v1_q    <= rd_v1_d;
      rd_d1_q    <= rd_d1_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Array storage is not reset. Writes are suppressed while rst_n is low so
  // a held reset does not keep clobbering word 0 through the sweep port.
  always_ff @(posedge clock) begin
    if (mem_we && rst_n) begin
      for (int i = 0; i < BE_W; i++) begin
        if (mem_wbe[i]) begin
          mem_q[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_gen_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_gen_ctrl
//   Two instances: u_dut0 (16x1024, OUT_REG=1) carries most directed steps,
//   u_dut1 (16x16, OUT_REG=0) covers the short sweep and latency-1 reads.
//   Reads push model data and the edge on which rd_valid must be seen
//   (accept edge + latency); the monitors pop and compare on rd_valid.
// ---------------------------------------------------------------------------
module tb_mem_gen_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mem_gen_ctrl_if #(.DATA_W(16), .ADDR_W(10)) bus0 ();
  mem_gen_ctrl_if #(.DATA_W(16), .ADDR_W(4))  bus1 ();

  mem_gen_ctrl #(.DATA_W(16), .ADDR_W(10), .OUT_REG(1'b1), .INIT_CLEAR(1'b1)) u_dut0 (
    .clock (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  mem_gen_ctrl #(.DATA_W(16), .ADDR_W(4), .OUT_REG(1'b0), .INIT_CLEAR(1'b1)) u_dut1 (
    .clock (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  logic [15:0] exp_q0[$];
  int          due_q0[$];
  logic [15:0] exp_q1[$];
  int          due_q1[$];
  logic [15:0] model0 [1024];
  logic [15:0] model1 [16];
  int          acc_cnt0 = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // rd_valid seen here is sampled by the edge at cyc+1.
  always @(negedge clk) begin
    if (rst_n && bus0.rd_valid) begin
      if (exp_q0.size() == 0) begin
        check("rd0_unexpected", 1, 0);
      end else begin
        check("rd0_data", bus0.rd_data, exp_q0.pop_front());
        check("rd0_latency", cyc + 1, due_q0.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus1.rd_valid) begin
      if (exp_q1.size() == 0) begin
        check("rd1_unexpected", 1, 0);
      end else begin
        check("rd1_data", bus1.rd_data, exp_q1.pop_front());
        check("rd1_latency", cyc + 1, due_q1.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (bus0.req_valid && bus0.req_ready) acc_cnt0++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic clear_models();
    foreach (model0[i]) model0[i] = '0;
    foreach (model1[i]) model1[i] = '0;
  endtask

  // Called and returns #1 after a rising edge. One request, held until accepted.
  task automatic do_req(input int sel, input bit we, input logic [9:0] a,
                        input logic [15:0] d, input logic [1:0] be);
    bit ok;
    int acc;
    logic rdy;
    ok  = 1'b0;
    acc = 0;
    if (sel == 0) begin
      bus0.wr_en = we; bus0.addr = a; bus0.wr_data = d; bus0.wr_be = be; bus0.req_valid = 1'b1;
    end else begin
      bus1.wr_en = we; bus1.addr = a[3:0]; bus1.wr_data = d; bus1.wr_be = be; bus1.req_valid = 1'b1;
    end
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      rdy = (sel == 0) ? bus0.req_ready : bus1.req_ready;
      if (rdy) begin
        ok  = 1'b1;
        acc = cyc + 1;
      end
      @(posedge clk);
      #1;
    end
    bus0.req_valid = 1'b0;
    bus1.req_valid = 1'b0;
    if (!ok) begin
      check("req_timeout", 0, 1);
    end else if (we) begin
      for (int i = 0; i < 2; i++) begin
        if (be[i]) begin
          if (sel == 0) model0[a][8*i +: 8] = d[8*i +: 8];
          else          model1[a[3:0]][8*i +: 8] = d[8*i +: 8];
        end
      end
    end else if (sel == 0) begin
      exp_q0.push_back(model0[a]);
      due_q0.push_back(acc + 2);
    end else begin
      exp_q1.push_back(model1[a[3:0]]);
      due_q1.push_back(acc + 1);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q0.size() + exp_q1.size()) != 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", exp_q0.size() + exp_q1.size(), 0);
  endtask

  // Called #1 after reset release; counts cycles spent sweeping.
  task automatic wait_init();
    int n0, n1, z0, z1, n;
    n0 = 0; n1 = 0; z0 = 0; z1 = 0; n = 0;
    while (!(bus0.init_done && bus1.init_done) && n < 1200) begin
      @(negedge clk);
      n++;
      if (!bus0.init_done) n0++;
      if (!bus1.init_done) n1++;
      if (!bus0.req_ready) z0++;
      if (!bus1.req_ready) z1++;
    end
    check("init_cycles0", n0, 1024);
    check("init_cycles1", n1, 16);
    check("ready_low0", z0, 1024);
    check("ready_low1", z1, 16);
    check("dbg_state0_run", bus0.dbg_state, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state();
    check("rst_ready0", bus0.req_ready, 0);
    check("rst_valid0", bus0.rd_valid, 0);
    check("rst_data0", bus0.rd_data, 0);
    check("rst_init0", bus0.init_done, 0);
    check("rst_dbg0", bus0.dbg_state, 0);
    check("rst_ready1", bus1.req_ready, 0);
    check("rst_data1", bus1.rd_data, 0);
    check("rst_init1", bus1.init_done, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [9:0]  ra;
    logic [15:0] rd;
    bit          rw;
    logic [1:0]  rb;
    int          a0, acc;

    rst_n = 1'b0;
    bus0.chip_en = 1'b1; bus0.req_valid = 1'b0; bus0.wr_en = 1'b0;
    bus0.addr = '0; bus0.wr_data = '0; bus0.wr_be = '0;
    bus1.chip_en = 1'b1; bus1.req_valid = 1'b0; bus1.wr_en = 1'b0;
    bus1.addr = '0; bus1.wr_data = '0; bus1.wr_be = '0;
    clear_models();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_init();

    // Sweep result on the small instance: all 16 words read as zero.
    for (int i = 0; i < 16; i++) do_req(1, 1'b0, 10'(i), 16'h0, 2'b00);
    do_req(1, 1'b1, 10'h00F, 16'h5AA5, 2'b11);
    do_req(1, 1'b0, 10'h00F, 16'h0, 2'b00);
    drain();

    // Sweep result on the large instance at a few spots.
    do_req(0, 1'b0, 10'h000, 16'h0, 2'b00);
    do_req(0, 1'b0, 10'h155, 16'h0, 2'b00);
    do_req(0, 1'b0, 10'h3FF, 16'h0, 2'b00);

    // Full write then read the following cycle.
    do_req(0, 1'b1, 10'h3FF, 16'hA5C3, 2'b11);
    do_req(0, 1'b0, 10'h3FF, 16'h0, 2'b00);
    drain();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_valid", bus0.rd_valid, 0);
      check("hold_data", bus0.rd_data, 16'hA5C3);
    end
    @(posedge clk);
    #1;

    // Byte enables: low byte only, none, high byte only.
    do_req(0, 1'b1, 10'h010, 16'h1234, 2'b11);
    do_req(0, 1'b1, 10'h010, 16'hFFFF, 2'b01);
    do_req(0, 1'b0, 10'h010, 16'h0, 2'b00);
    do_req(0, 1'b1, 10'h010, 16'hBEEF, 2'b00);
    do_req(0, 1'b0, 10'h010, 16'h0, 2'b00);
    do_req(0, 1'b1, 10'h010, 16'hAB00, 2'b10);
    do_req(0, 1'b0, 10'h010, 16'h0, 2'b00);
    drain();
    check("be_model", model0[10'h010], 16'hABFF);

    // Back-to-back reads, then chip_en drops with them in flight.
    do_req(0, 1'b1, 10'h000, 16'h0011, 2'b11);
    do_req(0, 1'b1, 10'h001, 16'h0022, 2'b11);
    do_req(0, 1'b1, 10'h002, 16'h0033, 2'b11);
    do_req(0, 1'b1, 10'h003, 16'h0044, 2'b11);
    for (int i = 0; i < 4; i++) do_req(0, 1'b0, 10'(i), 16'h0, 2'b00);
    bus0.chip_en = 1'b0;
    @(negedge clk);
    check("chip_en_low_ready", bus0.req_ready, 0);
    @(posedge clk);
    #1;
    drain();
    check("chip_en_low_ready_end", bus0.req_ready, 0);
    bus0.chip_en = 1'b1;

    // Random mix over a small window so reads hit written words.
    for (int i = 0; i < 24; i++) begin
      ra = 10'($urandom_range(0, 7));
      rw = 1'($urandom_range(0, 1));
      rd = 16'($urandom);
      rb = 2'($urandom_range(0, 3));
      do_req(0, rw, ra, rd, rb);
    end
    drain();

    // Request held off while chip_en=0, taken once chip_en returns.
    a0 = acc_cnt0;
    bus0.chip_en = 1'b0;
    bus0.wr_en = 1'b0; bus0.addr = 10'h3FF; bus0.req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("holdoff_ready", bus0.req_ready, 0);
      @(posedge clk);
      #1;
    end
    bus0.chip_en = 1'b1;
    @(negedge clk);
    check("holdoff_release_ready", bus0.req_ready, 1);
    acc = cyc + 1;
    @(posedge clk);
    #1;
    bus0.req_valid = 1'b0;
    exp_q0.push_back(model0[10'h3FF]);
    due_q0.push_back(acc + 2);
    check("holdoff_one_accept", acc_cnt0 - a0, 1);
    drain();

    // Reset with a read in flight: no response, sweep restarts.
    do_req(0, 1'b0, 10'h010, 16'h0, 2'b00);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q0.delete(); due_q0.delete();
    exp_q1.delete(); due_q1.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_reset_state();
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_models();
    wait_init();
    do_req(0, 1'b0, 10'h3FF, 16'h0, 2'b00);
    do_req(0, 1'b0, 10'h010, 16'h0, 2'b00);
    do_req(0, 1'b0, 10'h001, 16'h0, 2'b00);
    do_req(1, 1'b0, 10'h00F, 16'h0, 2'b00);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
